// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (ins/dat) arbiter onto a single memory bus with ack timeout.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin ties; default is fixed data priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  mem_arbiter_clock_in,
  input  logic                  mem_arbiter_reset_in,
  input  logic                  ins_req_in,
  input  logic [ADDR_WIDTH-1:0] ins_addr_in,
  output logic                  ins_gnt_out,
  output logic                  ins_rvalid_out,
  output logic [DATA_WIDTH-1:0] ins_rdata_out,
  output logic                  ins_err_out,
  input  logic                  dat_req_in,
  input  logic                  dat_we_in,
  input  logic [ADDR_WIDTH-1:0] dat_addr_in,
  input  logic [DATA_WIDTH-1:0] dat_wdata_in,
  output logic                  dat_gnt_out,
  output logic                  dat_rvalid_out,
  output logic [DATA_WIDTH-1:0] dat_rdata_out,
  output logic                  dat_err_out,
  output logic                  mem_req_out,
  output logic                  mem_we_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_wdata_out,
  input  logic                  mem_ack_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata_in
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  state_t                state_q, state_d;
  logic                  dat_q, dat_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] ins_rdata_q, ins_rdata_d;
  logic [DATA_WIDTH-1:0] dat_rdata_q, dat_rdata_d;
  logic                  pick_dat;
  logic                  any_req;
  assign any_req = ins_req_in | dat_req_in;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // prefer_dat_q low after reset so ins wins the first tie
  logic prefer_dat_q;
  assign pick_dat = dat_req_in & (~ins_req_in | prefer_dat_q);
  always_ff @(posedge mem_arbiter_clock_in or negedge mem_arbiter_reset_in)
    if (!mem_arbiter_reset_in) prefer_dat_q <= 1'b0;
    else if (state_q == IDLE && any_req) prefer_dat_q <= ~pick_dat;
`else
  assign pick_dat = dat_req_in;
`endif
  always_comb begin
    state_d     = state_q;
    dat_d       = dat_q;
    we_d        = we_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ins_rdata_d = ins_rdata_q;
    dat_rdata_d = dat_rdata_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = BUSY;
        dat_d   = pick_dat;
        we_d    = pick_dat & dat_we_in;
        addr_d  = pick_dat ? dat_addr_in : ins_addr_in;
        wdata_d = pick_dat ? dat_wdata_in : '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      BUSY: if (mem_ack_in || cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
        // ack takes precedence over a coincident timeout
        state_d     = DONE;
        err_d       = ~mem_ack_in;
        ins_rdata_d = dat_q ? ins_rdata_q : (mem_ack_in ? mem_rdata_in : '0);
        dat_rdata_d = dat_q ? ((mem_ack_in && !we_q) ? mem_rdata_in : '0) : dat_rdata_q;
      end else cnt_d = cnt_q + 8'd1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge mem_arbiter_clock_in or negedge mem_arbiter_reset_in)
    if (!mem_arbiter_reset_in) begin
      state_q     <= IDLE;
      dat_q       <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      ins_rdata_q <= '0;
      dat_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ins_rdata_q <= ins_rdata_d;
      dat_rdata_q <= dat_rdata_d;
    end
  logic first_busy, done;
  assign first_busy     = state_q == BUSY && cnt_q == 8'd0;
  assign done           = state_q == DONE;
  assign ins_gnt_out    = first_busy & ~dat_q;
  assign dat_gnt_out    = first_busy & dat_q;
  assign ins_rvalid_out = done & ~dat_q;
  assign dat_rvalid_out = done & dat_q;
  assign ins_err_out    = done & ~dat_q & err_q;
  assign dat_err_out    = done & dat_q & err_q;
  assign ins_rdata_out  = ins_rdata_q;
  assign dat_rdata_out  = dat_rdata_q;
  assign mem_req_out    = state_q == BUSY;
  assign mem_we_out     = we_q;
  assign mem_addr_out   = addr_q;
  assign mem_wdata_out  = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter; grants/bus and completions checked by a monitor.
module tb_mem_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ins_req_in = 0, dat_req_in = 0, dat_we_in = 0;
  logic [31:0] ins_addr_in = 0, dat_addr_in = 0, dat_wdata_in = 0;
  logic ins_gnt_out, ins_rvalid_out, ins_err_out, dat_gnt_out, dat_rvalid_out, dat_err_out;
  logic [31:0] ins_rdata_out, dat_rdata_out;
  logic mem_req_out, mem_we_out, mem_ack_in;
  logic [31:0] mem_addr_out, mem_wdata_out, mem_rdata_in;
  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .mem_arbiter_clock_in(clk), .mem_arbiter_reset_in(rst_n),
    .ins_req_in(ins_req_in), .ins_addr_in(ins_addr_in),
    .ins_gnt_out(ins_gnt_out), .ins_rvalid_out(ins_rvalid_out),
    .ins_rdata_out(ins_rdata_out), .ins_err_out(ins_err_out),
    .dat_req_in(dat_req_in), .dat_we_in(dat_we_in), .dat_addr_in(dat_addr_in),
    .dat_wdata_in(dat_wdata_in), .dat_gnt_out(dat_gnt_out), .dat_rvalid_out(dat_rvalid_out),
    .dat_rdata_out(dat_rdata_out), .dat_err_out(dat_err_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_ack_in(mem_ack_in), .mem_rdata_in(mem_rdata_in)
  );

  typedef struct { bit dat; logic [31:0] addr; bit we; logic [31:0] wdata; } gnt_t;
  typedef struct { bit dat; logic [31:0] rdata; bit err; int busy; } cpl_t;
  gnt_t gq[$];
  cpl_t cq[$];
  int vectors = 0, errors = 0;
  int ack_delay = 0;
  logic [31:0] rd_data = 0;
  bit ack_idle = 0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  task automatic flag(input string n);
    vectors++;
    errors++;
    $display("FAIL %s at %0t", n, $time);
  endtask

  // memory model: ack after ack_delay BUSY cycles (-1 = never)
  initial begin
    int n = 0;
    mem_ack_in = 0;
    mem_rdata_in = 0;
    forever begin
      @(negedge clk);
      if (mem_req_out && !mem_ack_in) begin
        mem_ack_in = (n == ack_delay);
        mem_rdata_in = mem_ack_in ? rd_data : ~rd_data;
        n++;
      end else begin
        mem_ack_in = ack_idle;
        mem_rdata_in = ~rd_data;
        n = 0;
      end
    end
  end

  // monitor
  initial begin
    gnt_t g;
    cpl_t c;
    int busy = 0;
    g = '{0, 0, 0, 0};
    forever begin
      @(negedge clk);
      if (ins_gnt_out | dat_gnt_out) begin
        busy = 0;
        if (gq.size() == 0) flag("unexpected_gnt");
        else begin
          g = gq.pop_front();
          chk("gnt_dat", {ins_gnt_out, dat_gnt_out}, {~g.dat, g.dat});
        end
      end
      if (mem_req_out) begin
        busy++;
        chk("bus", {mem_addr_out, mem_wdata_out}, {g.addr, g.wdata});
        chk("bus_we", mem_we_out, g.we);
      end
      if (ins_rvalid_out | dat_rvalid_out) begin
        if (cq.size() == 0) flag("unexpected_rvalid");
        else begin
          c = cq.pop_front();
          chk("cpl_who", {ins_rvalid_out, dat_rvalid_out}, {~c.dat, c.dat});
          chk("cpl_rdata", c.dat ? dat_rdata_out : ins_rdata_out, c.rdata);
          chk("cpl_err", {ins_err_out, dat_err_out}, {~c.dat & c.err, c.dat & c.err});
          chk("cpl_busy", busy, c.busy);
        end
      end else chk("err_idle", {ins_err_out, dat_err_out}, 0);
    end
  end

  task automatic wait_gnt();
    int k;
    for (k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ins_gnt_out | dat_gnt_out) break;
    end
    if (k == 64) flag("gnt_wait_expired");
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 400 && (cq.size() != 0 || gq.size() != 0); k++) @(negedge clk);
    if (k == 400) flag("drain_expired");
    @(negedge clk);
  endtask

  task automatic txn(input bit dat, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rdata, input int delay, input bit to);
    ack_delay = to ? -1 : delay;
    rd_data = rdata;
    gq.push_back('{dat, addr, dat & we, dat ? wdata : 32'h0});
    cq.push_back('{dat, (to || (dat && we)) ? 32'h0 : rdata, to, to ? TO : delay + 1});
    if (dat) begin
      dat_req_in = 1; dat_we_in = we; dat_addr_in = addr; dat_wdata_in = wdata;
    end else begin
      ins_req_in = 1; ins_addr_in = addr;
    end
    wait_gnt();
    ins_req_in = 0; dat_req_in = 0;
    ins_addr_in = 32'hBAD0_0001; dat_addr_in = 32'hBAD0_0002; dat_wdata_in = 32'hBAD0_0003; dat_we_in = ~we;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt_rvalid_err", {ins_gnt_out, dat_gnt_out, ins_rvalid_out, dat_rvalid_out, ins_err_out, dat_err_out}, 0);
    chk("rst_rdata", {ins_rdata_out, dat_rdata_out}, 0);
    chk("rst_bus", {mem_addr_out, mem_wdata_out}, 0);
    chk("rst_req_we", {mem_req_out, mem_we_out}, 0);
    rst_n = 1;
    // contention: both request continuously, ack immediate
    ack_delay = 0;
    rd_data = 32'hCAFE_0001;
    ins_addr_in = 32'h200; dat_addr_in = 32'h300; dat_we_in = 0; dat_wdata_in = 32'h77;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      bit d = (i % 2) == 1;
`else
      bit d = 1'b1;
`endif
      gq.push_back('{d, d ? 32'h300 : 32'h200, 0, d ? 32'h77 : 32'h0});
      cq.push_back('{d, 32'hCAFE_0001, 0, 1});
    end
    ins_req_in = 1; dat_req_in = 1;
    repeat (4) wait_gnt();
    ins_req_in = 0; dat_req_in = 0;
    drain();
    // basic ins read
    txn(0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0);
    chk("ins_rdata_hold", ins_rdata_out, 32'hDEAD_BEEF);
    // dat write, ack delayed 5 cycles
    txn(1, 1, 32'h40, 32'h1234_5678, 32'h5555_AAAA, 5, 0);
    chk("dat_wr_rdata_zero", dat_rdata_out, 32'h0);
    chk("ins_rdata_hold2", ins_rdata_out, 32'hDEAD_BEEF);
    // dat read, then timeout, then normal
    txn(1, 0, 32'h44, 32'h0, 32'h0BAD_F00D, 2, 0);
    txn(1, 0, 32'h48, 32'h0, 32'h1111_2222, 0, 1);
    chk("to_rdata_zero", dat_rdata_out, 32'h0);
    txn(1, 0, 32'h4C, 32'h0, 32'h3333_4444, 1, 0);
    // ack coincides with timeout: normal completion
    txn(0, 0, 32'h104, 32'h0, 32'h600D_0001, TO - 1, 0);
    // ack while idle is ignored
    ack_idle = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack_ignored", {mem_req_out, ins_rvalid_out, dat_rvalid_out}, 0);
    end
    ack_idle = 0;
    // reset during BUSY aborts silently
    ack_delay = -1;
    gq.push_back('{0, 32'h500, 0, 32'h0});
    ins_req_in = 1; ins_addr_in = 32'h500;
    wait_gnt();
    ins_req_in = 0;
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_mid_req", mem_req_out, 0);
    chk("rst_mid_rvalid", {ins_rvalid_out, dat_rvalid_out, ins_err_out, dat_err_out}, 0);
    repeat (3) @(negedge clk);
    chk("rst_mid_quiet", {mem_req_out, ins_rvalid_out, dat_rvalid_out}, 0);
    rst_n = 1;
    txn(0, 0, 32'h600, 32'h0, 32'h0F0F_0F0F, 2, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
